reaction_timer: RTL and testbench

- Downstream consumer of the 4-bit LFSR random generator in the reaction game.
- On each new random value, it waits a random delay, then lights the GO lamp and measures the player's reaction time in milliseconds.
- It reports three outcomes: a valid result, a false start (press before GO), or a timeout. The reaction value feeds the score/display stage.

---
 rtl/rng_game_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/reaction_timer.sv | 163 ++++++++++++++++
 tb/tb_reaction_timer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rng_game_pkg.sv
// Shared definitions for the reaction game: FSM state encoding and the
// default timing constants used by the RNG, timer and display stages.
package rng_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GO    = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int TICK_DIV_DEF  = 50000;
    localparam int STEP_MS_DEF   = 250;
    localparam int MIN_STEPS_DEF = 2;

    // Step count holds rng_value + MIN_STEPS; 5 bits covers 15 + 2.
    localparam int STEP_W = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a 1 ms tick; clr restarts the count so the first
// tick after a clear arrives TICK_DIV cycles later.
module tick_prescaler
    import rng_game_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: waits a random delay after a new RNG value, lights GO,
// then measures the press latency in ms (or flags false start / timeout).
module reaction_timer
    import rng_game_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int STEP_MS   = STEP_MS_DEF,
    parameter int MIN_STEPS = MIN_STEPS_DEF,
    parameter int RT_W      = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rng_en,
    input  logic [3:0]      rng_value,
    input  logic            btn,
    output logic            go_led,
    output logic            busy,
    output logic            result_valid,
    output logic [RT_W-1:0] reaction_ms,
    output logic            false_start,
    output logic            timeout
);

    localparam int MS_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(STEP_MS - 1);
    localparam logic [RT_W-1:0] RT_MAX  = '1;
    localparam logic [RT_W-1:0] RT_LAST = RT_MAX - RT_W'(1);

    state_t            state_reg, state_next;
    logic              rng_en_prev_reg;
    logic [STEP_W-1:0] step_reg;
    logic [MS_W-1:0]   ms_reg;
    logic [RT_W-1:0]   rt_reg;
    logic [RT_W-1:0]   reaction_reg;
    logic              false_start_reg;
    logic              timeout_reg;

    logic              tick;
    logic              clr;
    logic              start_run;
    logic              expire;
    logic              false_hit;
    logic              press_hit;
    logic              timeout_hit;
    logic [STEP_W-1:0] step_load;

    assign step_load = STEP_W'(rng_value) + STEP_W'(MIN_STEPS);
    assign clr       = (state_next != state_reg);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The button is examined before delay expiry / timeout in every state.
    always_comb begin
        state_next  = state_reg;
        start_run   = 1'b0;
        expire      = 1'b0;
        false_hit   = 1'b0;
        press_hit   = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rng_en && !rng_en_prev_reg) begin
                    start_run  = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!btn) begin
                    false_hit  = 1'b1;
                    state_next = DONE;
                end else if (tick && (ms_reg == MS_LAST) && (step_reg <= STEP_W'(1))) begin
                    expire     = 1'b1;
                    state_next = GO;
                end
            end
            GO: begin
                if (!btn) begin
                    press_hit  = 1'b1;
                    state_next = DONE;
                end else if (tick && (rt_reg == RT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rng_en_prev_reg <= 1'b0;
            step_reg        <= '0;
            ms_reg          <= '0;
            rt_reg          <= '0;
            reaction_reg    <= '0;
            false_start_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            rng_en_prev_reg <= rng_en;
            if (start_run) begin
                step_reg        <= step_load;
                ms_reg          <= '0;
                rt_reg          <= '0;
                reaction_reg    <= '0;
                false_start_reg <= 1'b0;
                timeout_reg     <= 1'b0;
            end else begin
                if ((state_reg == ARMED) && tick) begin
                    if (ms_reg == MS_LAST) begin
                        ms_reg   <= '0;
                        step_reg <= step_reg - STEP_W'(1);
                    end else begin
                        ms_reg <= ms_reg + MS_W'(1);
                    end
                end
                if (expire) begin
                    rt_reg <= '0;
                end else if ((state_reg == GO) && tick) begin
                    rt_reg <= rt_reg + RT_W'(1);
                end
                if (false_hit) begin
                    false_start_reg <= 1'b1;
                    reaction_reg    <= '0;
                end
                if (press_hit) begin
                    reaction_reg <= rt_reg;
                end
                if (timeout_hit) begin
                    reaction_reg <= RT_MAX;
                    timeout_reg  <= 1'b1;
                end
            end
        end
    end

    assign go_led       = (state_reg == GO);
    assign busy         = (state_reg != IDLE);
    assign result_valid = (state_reg == DONE);
    assign reaction_ms  = reaction_reg;
    assign false_start  = false_start_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed + random bench for reaction_timer against a cycle-count model
// derived from the delay / tick arithmetic of the game rules.
module tb_reaction_timer;

    localparam int TD    = 4;
    localparam int SMS   = 2;
    localparam int MINS  = 1;
    localparam int RTW   = 4;
    localparam int RTMAX = (1 << RTW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           rng_en;
    logic [3:0]     rng_value;
    logic           btn;
    logic           go_led;
    logic           busy;
    logic           result_valid;
    logic [RTW-1:0] reaction_ms;
    logic           false_start;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    reaction_timer #(
        .TICK_DIV  (TD),
        .STEP_MS   (SMS),
        .MIN_STEPS (MINS),
        .RT_W      (RTW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rng_en       (rng_en),
        .rng_value    (rng_value),
        .btn          (btn),
        .go_led       (go_led),
        .busy         (busy),
        .result_valid (result_valid),
        .reaction_ms  (reaction_ms),
        .false_start  (false_start),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // k: ARMED-relative cycle where btn goes low (-1 = never).
    // hold: cycles rng_en stays high; re_at: cycle rng_en rises again (-1 = never).
    task automatic run(input string tag, input int v, input int k, input int hold, input int re_at);
        int   d;
        int   j;
        int   done_idx;
        int   exp_rms;
        logic exp_fs;
        logic exp_tmo;
        d = (v + MINS) * SMS * TD;
        if (k >= 0 && k < d) begin
            exp_fs   = 1'b1;
            exp_tmo  = 1'b0;
            exp_rms  = 0;
            done_idx = k + 1;
        end else begin
            exp_fs = 1'b0;
            j = (k < 0) ? (1 << 20) : (k - d);
            if (j < RTMAX * TD) begin
                exp_tmo  = 1'b0;
                exp_rms  = j / TD;
                done_idx = d + j + 1;
            end else begin
                exp_tmo  = 1'b1;
                exp_rms  = RTMAX;
                done_idx = d + RTMAX * TD;
            end
        end
        rng_value = 4'(v);
        rng_en    = 1'b1;
        btn       = 1'b1;
        step_cycle();
        for (int c = 0; c <= done_idx + 1; c++) begin
            btn    = !(k >= 0 && c >= k && c <= done_idx);
            rng_en = (c < hold) || (re_at >= 0 && c >= re_at);
            check($sformatf("%s.flags@%0d", tag, c), {29'd0, busy, go_led, result_valid},
                  {29'd0, c <= done_idx, (c >= d) && (c < done_idx) && !exp_fs, c == done_idx});
            if (c >= done_idx) begin
                check($sformatf("%s.reaction_ms@%0d", tag, c), 32'(reaction_ms), 32'(exp_rms));
                check($sformatf("%s.false_start@%0d", tag, c), 32'(false_start), 32'(exp_fs));
                check($sformatf("%s.timeout@%0d", tag, c), 32'(timeout), 32'(exp_tmo));
            end
            step_cycle();
        end
        btn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s.idle_busy@%0d", tag, c), 32'(busy), 32'd0);
            step_cycle();
        end
        rng_en = 1'b0;
        step_cycle();
        step_cycle();
        $display("run %s: v=%0d press=%0d -> reaction_ms=%0d false_start=%0d timeout=%0d",
                 tag, v, k, reaction_ms, false_start, timeout);
    endtask

    initial begin
        int d;
        int v;
        int k;

        rst       = 1'b0;
        rng_en    = 1'b0;
        rng_value = 4'd0;
        btn       = 1'b1;
        repeat (3) step_cycle();
        check("reset.outputs", {26'd0, busy, go_led, result_valid, false_start, timeout, 1'b0},
              32'd0);
        check("reset.reaction_ms", 32'(reaction_ms), 32'd0);
        rst = 1'b1;
        step_cycle();
        step_cycle();
        $display("reset released");

        // Normal run: GO after 32 cycles, press 20 cycles later -> 5 ms.
        run("normal", 3, 32 + 20, 2, -1);
        run("false_start", 0, 3, 2, -1);
        run("timeout", 1, -1, 2, -1);
        run("retrigger", 15, 128 + 30, 100, 128 + 5);
        run("min_delay", 0, 8 + 9, 2, -1);
        run("max_delay", 15, 128 + 2, 2, -1);
        run("expiry_press", 2, 24 - 1, 2, -1);
        run("go_entry_press", 2, 24, 2, -1);
        run("press_on_entry", 5, 0, 2, -1);
        run("last_before_timeout", 0, 8 + RTMAX * TD - 1, 2, -1);

        // Reset while GO is lit: outputs clear immediately, no result pulse.
        rng_value = 4'd2;
        rng_en    = 1'b1;
        d         = (2 + MINS) * SMS * TD;
        step_cycle();
        for (int c = 0; c < d + 10; c++) begin
            rng_en = (c < 2);
            step_cycle();
        end
        check("midgo.go_led", 32'(go_led), 32'd1);
        rst = 1'b0;
        #1;
        check("midgo.async_clear", {26'd0, busy, go_led, result_valid, false_start, timeout, 1'b0},
              32'd0);
        check("midgo.reaction_ms", 32'(reaction_ms), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step_cycle();
            check($sformatf("midgo.no_pulse@%0d", c), {30'd0, busy, result_valid}, 32'd0);
        end
        rst = 1'b1;
        step_cycle();
        step_cycle();
        $display("reset mid-GO applied and released");
        run("post_reset", 2, d + 13, 2, -1);

        for (int r = 0; r < 8; r++) begin
            v = int'($urandom_range(15, 0));
            d = (v + MINS) * SMS * TD;
            if ($urandom_range(3, 0) == 0) k = -1;
            else k = int'($urandom_range(d + 70, 0));
            run($sformatf("rand%0d", r), v, k, int'($urandom_range(6, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
